// File: rtl/alu_sequencer.sv
// Request FIFO feeding an external ALU one operation at a time, with a single-entry response stage.
// Define ALU_SEQ_OPCHECK_EN to answer illegal opcodes with an error response instead of issuing them.
`timescale 1ns/1ps
module alu_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(ALU_LAT + 2);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAT_CNT  = CW'(ALU_LAT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [31:0]   r_fifo_a  [FIFO_DEPTH];
  logic [31:0]   r_fifo_b  [FIFO_DEPTH];
  logic [3:0]    r_fifo_op [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic          w_bypass;
  logic          w_capture;
  logic          w_rsp_done;
  logic          w_head_ok;
  logic [31:0]   w_head_a;
  logic [31:0]   w_head_b;
  logic [3:0]    w_head_op;

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_alu_a;
  logic [31:0]   r_alu_b;
  logic [3:0]    r_alu_op;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_result;
  logic          r_rsp_zero;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == (AW + 1)'(0));
  // A push is gated by full alone, so a same-cycle pop can never make room for it.
  assign w_push    = req_valid && !w_full;
  assign w_head_a  = r_fifo_a[r_rd_ptr];
  assign w_head_b  = r_fifo_b[r_rd_ptr];
  assign w_head_op = r_fifo_op[r_rd_ptr];

`ifdef ALU_SEQ_OPCHECK_EN
  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0010, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1010: op_is_legal = 1'b1;
      default:                   op_is_legal = 1'b0;
    endcase
  endfunction

  assign w_head_ok = op_is_legal(w_head_op);
`else
  assign w_head_ok = 1'b1;
`endif

  // FIFO storage; contents are only read after being written, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_a[r_wr_ptr]  <= req_a;
      r_fifo_b[r_wr_ptr]  <= req_b;
      r_fifo_op[r_wr_ptr] <= req_op;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_bypass    = 1'b0;
    w_capture   = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head_ok) begin
            w_issue     = 1'b1;
            w_state_nxt = ST_EXEC;
          end else begin
            w_bypass    = 1'b1;
            w_state_nxt = ST_RESP;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // r_cnt reaches ALU_LAT on the edge ALU_LAT after issue; capture on the next one.
        if (r_cnt == LAT_CNT) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ALU operand registers, loaded only on issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a  <= 32'd0;
      r_alu_b  <= 32'd0;
      r_alu_op <= 4'b0000;
    end else if (w_issue) begin
      r_alu_a  <= w_head_a;
      r_alu_b  <= w_head_b;
      r_alu_op <= w_head_op;
    end
  end

  // ALU latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_issue) begin
      r_cnt <= '0;
    end else if (r_state == ST_EXEC) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Response payload and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= 32'd0;
      r_rsp_zero   <= 1'b0;
    end else if (w_capture) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_result <= alu_result;
      r_rsp_zero   <= alu_zero;
    end else if (w_bypass) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_result <= 32'd0;
      r_rsp_zero   <= 1'b1;
    end else if (w_rsp_done) begin
      r_rsp_valid  <= 1'b0;
    end
  end

`ifdef ALU_SEQ_OPCHECK_EN
  logic r_rsp_err;

  // Error flag marks responses produced without issuing to the ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_err <= 1'b0;
    end else if (w_bypass) begin
      r_rsp_err <= 1'b1;
    end else if (w_capture) begin
      r_rsp_err <= 1'b0;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready  = !w_full;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign busy       = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: acts as a pipelined ALU, checks responses against a scoreboard.
// Honours ALU_SEQ_OPCHECK_EN for the illegal-opcode expectations.
`timescale 1ns/1ps
module tb_alu_sequencer;

  localparam int LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;
  logic        busy;

  alu_sequencer #(.FIFO_DEPTH(4), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      4'b0000: alu_f = a + b;
      4'b0010: alu_f = a - b;
      4'b0100: alu_f = a & b;
      4'b0101: alu_f = a | b;
      4'b0110: alu_f = a ^ b;
      4'b0111: alu_f = ~(a | b);
      4'b1010: alu_f = {31'd0, ($signed(a) < $signed(b))};
      default: alu_f = 32'hA5A5_A5A5;
    endcase
  endfunction

  // External ALU: result is valid LAT cycles after its operands settle
  logic [31:0] pipe [LAT];
  always_ff @(posedge clk) begin
    pipe[0] <= alu_f(alu_a, alu_b, alu_op);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign alu_result = pipe[LAT-1];
  assign alu_zero   = (alu_result == 32'd0);

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];
  int   n_total = 0;
  int   n_bad   = 0;
  int   n_rsp   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                      input logic [31:0] res, input logic zero, input logic err,
                      output int waits);
    exp_t e;
    int   c;
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    c = 0;
    while (!req_ready && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    if (req_ready) begin
      e.res = res; e.zero = zero; e.err = err;
      sb_q.push_back(e);
      @(posedge clk); #1;
    end else begin
      check("push_timeout", {31'd0, req_ready}, 32'd1);
    end
    req_valid = 1'b0;
    waits = c;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int c;
    c = 0;
    while (n_rsp < target && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check("rsp_count", 32'(n_rsp), 32'(target));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"},  {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_result"}, rsp_result,         32'd0);
    check({tag, "_rsp_zero"},   {31'd0, rsp_zero},  32'd0);
    check({tag, "_rsp_err"},    {31'd0, rsp_err},   32'd0);
    check({tag, "_alu_a"},      alu_a,              32'd0);
    check({tag, "_alu_b"},      alu_b,              32'd0);
    check({tag, "_alu_op"},     {28'd0, alu_op},    32'd0);
    check({tag, "_busy"},       {31'd0, busy},      32'd0);
  endtask

  initial begin
    int   w;
    int   base;
    exp_t e;

    vecs[0] = '{32'd9,         32'd9,         4'b0010, 32'd0,         1'b1};
    vecs[1] = '{32'hFFFF_FFFF, 32'd1,         4'b1010, 32'd1,         1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'd1,         4'b0000, 32'd0,         1'b1};
    vecs[3] = '{32'd0,         32'd1,         4'b0010, 32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0100, 32'hF000_F000, 1'b0};
    vecs[5] = '{32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b0101, 32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h1234_5678, 4'b0110, 32'd0,         1'b1};
    vecs[7] = '{32'd0,         32'd0,         4'b0111, 32'hFFFF_FFFF, 1'b0};
    vecs[8] = '{32'd1,         32'hFFFF_FFFF, 4'b1010, 32'd0,         1'b1};
    vecs[9] = '{32'h7FFF_FFFF, 32'h8000_0000, 4'b1010, 32'd0,         1'b1};

    rst_n = 1'b0; req_valid = 1'b0; req_a = 32'd0; req_b = 32'd0; req_op = 4'd0;
    rsp_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && rsp_valid && rsp_ready) begin
          check("sb_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("rsp_result", rsp_result,        e.res);
            check("rsp_zero",   {31'd0, rsp_zero}, {31'd0, e.zero});
            check("rsp_err",    {31'd0, rsp_err},  {31'd0, e.err});
          end
          n_rsp++;
        end
      end
    join_none

    cycles(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // add: response appears LAT+2 edges after the push edge
    push(32'd5, 32'd7, 4'b0000, 32'd12, 1'b0, 1'b0, w);
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge clk); #1;
      check($sformatf("lat_valid_e%0d", k), {31'd0, rsp_valid}, {31'd0, (k == LAT + 2)});
      if (k == 1) check("busy_exec", {31'd0, busy}, 32'd1);
    end
    wait_rsp(1, 20);

    // table of operations, pushed back to back
    base = n_rsp;
    for (int i = 0; i < 10; i++) begin
      push(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].zero, 1'b0, w);
    end
    wait_rsp(base + 10, 200);

    // backpressure: 5 accepted, sixth stalls until responses drain
    cycles(2);
    rsp_ready = 1'b0;
    base = n_rsp;
    for (int i = 0; i < 5; i++) begin
      push(32'(i * 3), 32'd100, 4'b0000, 32'(100 + i * 3), 1'b0, 1'b0, w);
      check($sformatf("bp_push%0d_wait", i), 32'(w), 32'd0);
    end
    check("bp_full", {31'd0, req_ready}, 32'd0);
    req_a = 32'd999; req_b = 32'd1; req_op = 4'b0000; req_valid = 1'b1;
    cycles(8);
    check("bp_still_full", {31'd0, req_ready}, 32'd0);
    check("bp_no_rsp", 32'(n_rsp), 32'(base));
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_rsp(base + 5, 200);
    cycles(10);
    check("bp_only5", 32'(n_rsp), 32'(base + 5));

    // illegal opcode
    base = n_rsp;
`ifdef ALU_SEQ_OPCHECK_EN
    push(32'd3, 32'd4, 4'b1111, 32'd0, 1'b1, 1'b1, w);
    wait_rsp(base + 1, 20);
    check("ill_alu_op", {28'd0, alu_op}, 32'd0);
    check("ill_alu_a",  alu_a,           32'd12);
`else
    push(32'd3, 32'd4, 4'b1111, 32'hA5A5_A5A5, 1'b0, 1'b0, w);
    wait_rsp(base + 1, 20);
    check("ill_alu_op", {28'd0, alu_op}, 32'h0000_000F);
    check("ill_alu_a",  alu_a,           32'd3);
`endif

    // reset with one op in EXEC and two queued
    cycles(2);
    push(32'd1, 32'd2, 4'b0000, 32'd3, 1'b0, 1'b0, w);
    push(32'd4, 32'd5, 4'b0000, 32'd9, 1'b0, 1'b0, w);
    push(32'd6, 32'd7, 4'b0000, 32'd13, 1'b0, 1'b0, w);
    rst_n = 1'b0;
    sb_q.delete();
    base = n_rsp;
    #3;
    check_reset_outputs("midrst");
    cycles(2);
    rst_n = 1'b1;
    cycles(12);
    check("midrst_no_rsp", 32'(n_rsp), 32'(base));
    check("midrst_idle", {31'd0, busy}, 32'd0);
    push(32'd20, 32'd22, 4'b0000, 32'd42, 1'b0, 1'b0, w);
    wait_rsp(base + 1, 20);
    cycles(2);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("final_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning request FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter ALU_LAT, default 2, meaning ALU cycles from operand register to valid result (>=1).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have ports req_valid input 1, req_ready output 1, req_a input 32, req_b input 32, req_op input 4, meaning the request handshake and its operands/opcode.
REQ-006 SHALL have ports alu_a output 32, alu_b output 32, alu_op output 4, meaning operands/opcode driven to the downstream ALU.
REQ-007 SHALL have ports alu_result input 32, alu_zero input 1, meaning the ALU outputs.
REQ-008 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_result output 32, rsp_zero output 1, rsp_err output 1, meaning the response handshake and its payload.
REQ-009 SHALL have port busy output 1, meaning the FSM is not IDLE or the FIFO is not empty.

Function
REQ-010 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1, pushing {a,b,op} into the FIFO.
REQ-011 SHALL drive req_ready = FIFO not full; a push when full SHALL be impossible even if a pop occurs in the same cycle.
REQ-012 SHALL perform push and pop in the same cycle when both are legal, with occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-013 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-014 IDLE: if FIFO non-empty, SHALL pop the head, register it onto alu_a/alu_b/alu_op, clear the latency counter and go to EXEC; otherwise it SHALL stay in IDLE.
REQ-015 EXEC: SHALL hold alu_a/alu_b/alu_op stable and increment the counter each cycle.
REQ-016 EXEC: on the (ALU_LAT+1)th rising edge after the operand-register edge, SHALL capture alu_result into rsp_result and alu_zero into rsp_zero, and go to RESP; with the default this is the 3rd edge.
REQ-017 RESP: SHALL assert rsp_valid with a stable payload until rsp_ready=1 on a rising edge, then clear rsp_valid and go to IDLE.
REQ-018 SHALL issue at most one operation in flight; the next issue occurs no earlier than the IDLE cycle after the response handshake.
REQ-019 SHALL pass any 4-bit opcode to alu_op unmodified (legal set: 0000 add, 0010 sub, 0100 and, 0101 or, 0110 xor, 0111 nor, 1010 slt) unless REQ-025 applies.
REQ-020 SHALL keep alu_a/alu_b/alu_op at their last issued values outside EXEC.

Reset
REQ-021 While rst_n=0, SHALL force FIFO empty, FSM=IDLE, counter=0, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, alu_a=0, alu_b=0, alu_op=0000, busy=0; req_ready SHALL read 1 once rst_n=1.
REQ-022 Reset asserted mid-operation (EXEC or RESP) SHALL discard the in-flight operation and all queued requests; no response SHALL be produced for them.
REQ-023 Deassertion SHALL take effect on the first rising edge with rst_n=1; no request SHALL be accepted before that edge.

Configuration
REQ-024 Macro ALU_SEQ_OPCHECK_EN SHALL select opcode legality checking.
REQ-025 With ALU_SEQ_OPCHECK_EN defined, an illegal head opcode popped in IDLE SHALL bypass EXEC, leave the ALU outputs unchanged, and go directly to RESP with rsp_err=1, rsp_result=0, rsp_zero=1.
REQ-026 Without ALU_SEQ_OPCHECK_EN, rsp_err SHALL be tied 0 and all opcodes SHALL be issued per REQ-014.

Verification
REQ-027 Test add: op=0000, a=5, b=7, rsp_ready=1 -> rsp_result=12, rsp_zero=0, rsp_valid rising ALU_LAT+2 edges after the push edge.
REQ-028 Test sub and slt: op=0010, a=9, b=9 -> result 0, zero 1; then op=1010, a=0xFFFFFFFF, b=1 -> result 1, zero 0, in push order.
REQ-029 Test backpressure: rsp_ready=0 with 6 back-to-back requests -> 5 accepted (1 in EXEC plus 4 queued), req_ready=0 after the 5th; release rsp_ready -> 5 responses in order.
REQ-030 Test illegal opcode with macro: op=1111 -> rsp_err=1, result 0, zero 1, alu_op unchanged; without macro -> rsp_err=0 and alu_op=1111.
REQ-031 Test reset during EXEC with 2 queued -> all outputs at reset values, no responses; the next request after reset completes normally.
